// File: rtl/reduction_sequencer.sv
// reduction_sequencer: accumulates eight-operand groups over a LOW/HIGH two-step
// reduction and presents the 32-bit sum, sticky wrap flag and group count.
module reduction_sequencer #(
  parameter int W = 16
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           in_valid,
  output logic           in_ready,
  input  logic [8*W-1:0] in_data,
  input  logic           in_last,
  output logic           out_valid,
  input  logic           out_ready,
  output logic [31:0]    out_data,
  output logic           out_overflow,
  output logic [15:0]    out_count,
  output logic           busy
);
  // One extra bit above the widest addend captures the carry out of bit 31.
  localparam int SW = (W + 3 > 32 ? W + 3 : 32) + 1;
  typedef enum logic [1:0] {IDLE, LOW, HIGH, DONE} state_t;
  state_t         state;
  logic [8*W-1:0] data_r;
  logic           last_r;
  logic [W+1:0]   partial;
  logic [31:0]    acc;
  logic [W+1:0]   lo_sum;
  logic [W+1:0]   hi_sum;
  logic [SW-1:0]  total;
  always_comb begin
    lo_sum = '0;
    hi_sum = '0;
    for (int i = 0; i < 4; i++) begin
      lo_sum = lo_sum + (W+2)'(data_r[i*W +: W]);
      hi_sum = hi_sum + (W+2)'(data_r[(i+4)*W +: W]);
    end
    total = SW'(acc) + SW'(partial) + SW'(hi_sum);
  end
  assign in_ready  = state == IDLE;
  assign out_valid = state == DONE;
  assign busy      = state != IDLE;
  assign out_data  = acc;
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      state        <= IDLE;
      data_r       <= '0;
      last_r       <= 1'b0;
      partial      <= '0;
      acc          <= '0;
      out_overflow <= 1'b0;
      out_count    <= '0;
    end else
      case (state)
        IDLE: if (in_valid) begin
          data_r    <= in_data;
          last_r    <= in_last;
          out_count <= out_count + {15'd0, out_count != 16'hFFFF};
          state     <= LOW;
        end
        LOW: begin
          partial <= lo_sum;
          state   <= HIGH;
        end
        HIGH: begin
          acc          <= total[31:0];
          out_overflow <= out_overflow | (|total[SW-1:32]);
          state        <= last_r ? DONE : IDLE;
        end
        DONE: if (out_ready) begin
          acc          <= '0;
          out_overflow <= 1'b0;
          out_count    <= '0;
          state        <= IDLE;
        end
      endcase
endmodule

// File: tb/tb_reduction_sequencer.sv
// tb_reduction_sequencer: directed groups with hand-computed results, checked by a
// scoreboard monitor that compares every presented result against the queue head.
module tb_reduction_sequencer;
  localparam int W = 16;
  typedef struct {
    logic [31:0] d;
    logic        o;
    logic [15:0] c;
  } exp_t;
  logic           clk = 1'b0;
  logic           rst;
  logic           in_valid;
  logic           in_ready;
  logic [8*W-1:0] in_data;
  logic           in_last;
  logic           out_valid;
  logic           out_ready;
  logic [31:0]    out_data;
  logic           out_overflow;
  logic [15:0]    out_count;
  logic           busy;
  exp_t           q[$];
  int             checks = 0;
  int             errors = 0;
  int             cyc = 0;
  reduction_sequencer #(.W(W)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .in_last(in_last), .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .out_overflow(out_overflow), .out_count(out_count), .busy(busy)
  );
  always #5 clk = ~clk;
  always @(posedge clk) cyc++;
  task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s got=%0h want=%0h", nm, got, want);
    end
  endtask
  function automatic logic [8*W-1:0] rep(input logic [W-1:0] v);
    return {8{v}};
  endfunction
  task automatic push_exp(input logic [31:0] d, input logic o, input logic [15:0] c);
    exp_t e;
    e.d = d;
    e.o = o;
    e.c = c;
    q.push_back(e);
  endtask
  task automatic send(input logic [8*W-1:0] d, input logic l);
    int  n;
    logic ok;
    n = 0;
    in_data  = d;
    in_last  = l;
    in_valid = 1'b1;
    do begin
      @(negedge clk);
      ok = in_ready;
      @(posedge clk);
      #1;
      n++;
    end while (!ok && n < 50);
    if (!ok) chk("send_timeout", 0, 1);
    in_valid = 1'b0;
  endtask
  task automatic wait_valid();
    repeat (20) begin
      @(negedge clk);
      if (out_valid) break;
    end
    chk("valid_seen", out_valid, 1);
  endtask
  always @(negedge clk)
    if (!rst && out_valid) begin
      if (q.size() == 0) chk("unexpected_result", 1, 0);
      else begin
        chk("res_data", out_data, q[0].d);
        chk("res_ovf", out_overflow, q[0].o);
        chk("res_count", out_count, q[0].c);
        if (out_ready) void'(q.pop_front());
      end
    end
  initial begin
    logic [63:0] big;
    int s, xfer, last_c, bad_gap, ov;
    rst = 1'b1;
    in_valid = 1'b0;
    in_data = '0;
    in_last = 1'b0;
    out_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_in_ready", in_ready, 1);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_busy", busy, 0);
    chk("rst_count", out_count, 0);
    chk("rst_data", out_data, 0);
    chk("rst_ovf", out_overflow, 0);
    rst = 1'b0;
    @(posedge clk);
    #1;
    // single group of ones, latency counted from the cycle the group is offered
    push_exp(32'd8, 1'b0, 16'd1);
    s = cyc;
    send(rep(16'd1), 1'b1);
    wait_valid();
    chk("latency", cyc - s, 3);
    @(posedge clk);
    #1;
    push_exp(32'h0008_0000, 1'b0, 16'd2);
    send(rep(16'hFFFF), 1'b0);
    send(rep(16'd1), 1'b1);
    wait_valid();
    @(posedge clk);
    #1;
    // consumer stalls for five cycles
    out_ready = 1'b0;
    push_exp(32'd8, 1'b0, 16'd1);
    send(rep(16'd1), 1'b1);
    wait_valid();
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("stall_valid", out_valid, 1);
      chk("stall_in_ready", in_ready, 0);
      chk("stall_data", out_data, 8);
    end
    @(posedge clk);
    #1;
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    chk("consume_in_ready", in_ready, 1);
    chk("consume_valid", out_valid, 0);
    chk("consume_count", out_count, 0);
    // long run that wraps the 32-bit accumulator
    big = 64'd8193 * 64'd524280;
    push_exp(big[31:0], 1'b1, 16'd8193);
    for (int i = 0; i < 8193; i++) send(rep(16'hFFFF), i == 8192);
    wait_valid();
    @(posedge clk);
    #1;
    push_exp(32'd8, 1'b0, 16'd1);
    send(rep(16'd1), 1'b1);
    wait_valid();
    @(posedge clk);
    #1;
    // reset while the group is in HIGH
    send(rep(16'd5), 1'b0);
    @(posedge clk);
    #1;
    chk("pre_rst_busy", busy, 1);
    rst = 1'b1;
    #1;
    chk("midrst_valid", out_valid, 0);
    chk("midrst_in_ready", in_ready, 1);
    chk("midrst_busy", busy, 0);
    chk("midrst_count", out_count, 0);
    rst = 1'b0;
    @(posedge clk);
    #1;
    push_exp(32'd16, 1'b0, 16'd1);
    send(rep(16'd2), 1'b1);
    wait_valid();
    @(posedge clk);
    #1;
    // producer holds in_valid high across three groups
    in_data = rep(16'd3);
    in_last = 1'b0;
    in_valid = 1'b1;
    xfer = 0;
    last_c = -1;
    bad_gap = 0;
    ov = 0;
    repeat (9) begin
      @(negedge clk);
      if (out_valid) ov++;
      if (in_ready) begin
        if (last_c >= 0 && cyc - last_c != 3) bad_gap++;
        last_c = cyc;
        xfer++;
      end
    end
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    chk("hold_xfers", xfer, 3);
    chk("hold_gap", bad_gap, 0);
    chk("hold_no_valid", ov, 0);
    push_exp(32'd72, 1'b0, 16'd4);
    send('0, 1'b1);
    wait_valid();
    @(posedge clk);
    #1;
    repeat (10) begin
      if (q.size() == 0) break;
      @(posedge clk);
    end
    chk("queue_empty", q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
